mem_access_stage: RTL

Memory stage of the 16-bit pipelined processor, directly downstream of the EXE/MEM pipeline register. It takes the registered EXE results and control bits, performs loads and stores on the data memory through a variable-latency request/acknowledge port, and stalls the upstream pipeline while an access is outstanding. It also contains the MEM/WB pipeline register, selecting the write-back data and presenting it to the register-file write port in ID.

---
 rtl/mem_access_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory stage of the 16-bit pipeline: performs loads/stores over a req/ack data-memory
// port, stalls upstream while an access is outstanding, and holds the MEM/WB register.
module mem_access_stage #(
  parameter int ARQ      = 16,
  parameter int MEM_ADDR = 13,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_enable_mem_in,
  input  logic                rd_mem_mem_in,
  input  logic                wr_mem_mem_in,
  input  logic                mux_mem_mem_in,
  input  logic                pc_mem_in,
  input  logic [ARQ-1:0]      src3_mem_in,
  input  logic [ARQ-1:0]      alu_result_mem_in,
  input  logic [ARQ-1:0]      wb_imm_mem_in,
  input  logic [2:0]          wb_dest_mem_in,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [MEM_ADDR-1:0] dmem_addr,
  output logic [ARQ-1:0]      dmem_wdata,
  input  logic [ARQ-1:0]      dmem_rdata,
  input  logic                dmem_ack,
  output logic                stall_out,
  output logic                wb_enable_wb,
  output logic [2:0]          wb_dest_wb,
  output logic [ARQ-1:0]      wb_data_wb,
  output logic                pc_wb,
  output logic                mem_fault
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]     state;
  logic [CW-1:0]  req_cnt;
  logic           acc_load;
  logic           acc_wb_en;
  logic           acc_pc;
  logic [2:0]     acc_dest;
  logic           mem_op;
  logic           timeout_hit;
  logic           access_done;
  logic [ARQ-1:0] load_data;
  logic           unused_addr_bits;

  assign mem_op      = rd_mem_mem_in | wr_mem_mem_in;
  assign timeout_hit = (state == REQ) && !dmem_ack && (req_cnt == CNT_LAST);
  assign access_done = (state == REQ) && (dmem_ack || timeout_hit);
  // An aborted access completes as if the memory had returned zero.
  assign load_data   = dmem_ack ? dmem_rdata : '0;
  assign stall_out   = ((state == IDLE) && mem_op) ||
                       ((state == REQ) && !dmem_ack && !timeout_hit);

  assign unused_addr_bits = ^alu_result_mem_in[ARQ-1:MEM_ADDR];

  // Access sequencer: the port registers double as the latched access, so they
  // stay stable for the whole REQ phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_cnt    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      acc_load   <= 1'b0;
      acc_wb_en  <= 1'b0;
      acc_pc     <= 1'b0;
      acc_dest   <= '0;
      mem_fault  <= 1'b0;
    end else if (state == IDLE) begin
      if (mem_op) begin
        state      <= REQ;
        req_cnt    <= '0;
        dmem_req   <= 1'b1;
        dmem_we    <= wr_mem_mem_in & ~rd_mem_mem_in;
        dmem_addr  <= alu_result_mem_in[MEM_ADDR-1:0];
        dmem_wdata <= src3_mem_in;
        acc_load   <= rd_mem_mem_in;
        acc_wb_en  <= wb_enable_mem_in;
        acc_pc     <= pc_mem_in;
        acc_dest   <= wb_dest_mem_in;
      end
    end else if (access_done) begin
      state    <= IDLE;
      dmem_req <= 1'b0;
      if (timeout_hit) begin
        mem_fault <= 1'b1;
      end
    end else begin
      req_cnt <= req_cnt + 1'b1;
    end
  end

  // MEM/WB register: bubbles only clear the enable, the other fields hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_enable_wb <= 1'b0;
      wb_dest_wb   <= '0;
      wb_data_wb   <= '0;
      pc_wb        <= 1'b0;
    end else if (state == IDLE) begin
      if (mem_op) begin
        wb_enable_wb <= 1'b0;
      end else begin
        wb_enable_wb <= wb_enable_mem_in;
        wb_dest_wb   <= wb_dest_mem_in;
        wb_data_wb   <= mux_mem_mem_in ? wb_imm_mem_in : alu_result_mem_in;
        pc_wb        <= pc_mem_in;
      end
    end else if (access_done) begin
      wb_enable_wb <= acc_load & acc_wb_en;
      pc_wb        <= acc_pc;
      if (acc_load) begin
        wb_dest_wb <= acc_dest;
        wb_data_wb <= load_data;
      end
    end else begin
      wb_enable_wb <= 1'b0;
    end
  end

endmodule
